ld_imm_sequencer: RTL and testbench
===================================

// Module: ld_imm_sequencer
// PURPOSE
// Sequenced microcode unit for immediate loads: LD r,d8, LD (HL),d8 and LD rr,d16.
// Owns its own M-cycle/T-step counters instead of decoding external ones.
// Adds memory wait-state stalling and a busy/done handshake to the control unit.
// Drives the same one-hot control vector as the other microcode blocks; control unit ORs it in.
// PARAMETERS
// NUM_STEPS  4  T-steps per M-cycle (>=3); step 0=address, 1=PC increment, NUM_STEPS-1=data
// NUM_REG    8  width of one-hot 8-bit register select / o_Read8 / o_Write8
// PORTS
// i_Clk          in   1          system clock, all state on rising edge
// i_Reset_n      in   1          synchronous active-low reset
// i_Start        in   1          decoded opcode is an immediate load; sampled only when idle
// i_Mode         in   2          00 LD r,d8; 01 LD (HL),d8; 10 LD rr,d16; 11 reserved
// i_Y_Lo         in   NUM_REG    one-hot dest (d8 / low byte); bit7=A via ALU path, bit0=temp Z
// i_Y_Hi         in   NUM_REG    one-hot dest of high byte (mode 10 only)
// i_Wait         in   1          memory not ready; holds the sequencer on data steps
// o_Busy         out  1          sequence in progress
// o_Done         out  1          1-clk pulse, last clock of the instruction
// o_IR_Fetch     out  1          1-clk pulse with o_Done: fetch next opcode
// o_Cycle_Step   out  NUM_STEPS  one-hot current T-step (0 when idle)
// o_Cycle_Count  out  4          one-hot current M-cycle (0 when idle)
// o_Read8 / o_Write8  out NUM_REG   8-bit register file read / write selects
// o_Read16 / o_Write16 out 6        16-bit source/dest; bit5=PC, bit2=HL
// o_WriteALU8    out  2          bit0 = write A
// o_Move_Reg, o_Bus_In, o_Bus_Out, o_Address_Out  out 1  datapath strobes
// o_Increment16  out  2          bit0 = increment selected 16-bit reg
// BEHAVIOUR
// - Reset (i_Reset_n=0 at edge): state IDLE, counters cleared; every output 0. Overrides all, incl. mid-sequence.
// - All outputs decoded from registered state and latched selects only; no input->output comb path.
// - Accept: IDLE & i_Start & i_Mode!=11 -> latch i_Mode, i_Y_Lo, i_Y_Hi; next clk = M0 step0.
// - i_Start while busy ignored. i_Mode=11 ignored; stays IDLE.
// - Latched Y with >1 bit set: behaviour undefined, no check.
// - Per-M-cycle fields:
//   - IMM: step0 o_Address_Out, o_Read16[5]; step1 o_Increment16[0], o_Write16[5].
//   - IMM step NUM_STEPS-1: o_Bus_In; o_Write8 = dest & ~bit7; o_WriteALU8[0] = dest[7].
//   - WRHL: step0 o_Address_Out, o_Read16[2].
//   - WRHL step NUM_STEPS-1: o_Read8[0], o_Move_Reg, o_Bus_Out.
// - States:
//   - IDLE -> IMM_LO.
//   - IMM_LO -> {mode00: FETCH; mode01: WRHL; mode10: IMM_HI}.
//   - IMM_HI -> FETCH. WRHL -> FETCH. FETCH -> IDLE.
// - mode01 IMM_LO writes temp Z (o_Write8[0]) regardless of i_Y_Lo; IMM_HI uses i_Y_Hi.
// - Step counter advances each clk; wraps to step0 and bumps M-count at NUM_STEPS-1.
// - i_Wait=1 while on step NUM_STEPS-1: counters/state hold, strobes stay asserted.
// - Register/bus write commits only on the clk with i_Wait=0; i_Wait ignored on other steps.
// - FETCH is one clk: o_IR_Fetch=o_Done=1, o_Busy=1, then IDLE.
// - New i_Start sampled in that FETCH clk is accepted (back-to-back, no bubble); next clk = M0 step0.
// - Latency (no waits): mode00 NUM_STEPS+1 clks; mode01/10 2*NUM_STEPS+1 clks, accept edge to Done inclusive.
// TESTING
// - LD B,d8 (mode00, Y_Lo=8'h04, NUM_STEPS=4): Done 5 clks after accept.
//   - Bus_In & Write8=8'h04 at clk 4; Increment16=2'b01 at clk 2 only.
// - LD A,d8 (Y_Lo=8'h80): WriteALU8=2'b01 and Write8=8'h00 on data step.
// - LD (HL),d8: M0 Write8=8'h01; M1 step0 Read16=6'b000100.
//   - M1 step3: Bus_Out, Move_Reg, Read8=8'h01; Done at clk 9.
// - LD BC,d16 (Y_Lo=8'h02, Y_Hi=8'h04): Write8 8'h02 at clk 4, 8'h04 at clk 8.
//   - PC incremented exactly twice; Done at clk 9.
// - i_Wait high 3 clks on M0 step3 of mode00: Bus_In held 4 clks, single Write8 commit; Done at clk 8.
// - Reset low at M1 step1 of mode10: all outputs 0 next clk; i_Start with i_Mode=11 -> stays idle.

Source files
------------

// File: rtl/ld_imm_sequencer.sv
// Microcode sequencer for immediate loads (LD r,d8 / LD (HL),d8 / LD rr,d16).
// Owns its M-cycle and T-step counters; emits the shared one-hot control vector.
module ld_imm_sequencer #(
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned NUM_REG   = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  input  logic                 i_Start,
  input  logic [1:0]           i_Mode,
  input  logic [NUM_REG-1:0]   i_Y_Lo,
  input  logic [NUM_REG-1:0]   i_Y_Hi,
  input  logic                 i_Wait,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic                 o_IR_Fetch,
  output logic [NUM_STEPS-1:0] o_Cycle_Step,
  output logic [3:0]           o_Cycle_Count,
  output logic [NUM_REG-1:0]   o_Read8,
  output logic [NUM_REG-1:0]   o_Write8,
  output logic [5:0]           o_Read16,
  output logic [5:0]           o_Write16,
  output logic [1:0]           o_WriteALU8,
  output logic                 o_Move_Reg,
  output logic                 o_Bus_In,
  output logic                 o_Bus_Out,
  output logic                 o_Address_Out,
  output logic [1:0]           o_Increment16
);

  localparam int unsigned STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [1:0] MODE_R8  = 2'b00;
  localparam logic [1:0] MODE_HL  = 2'b01;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IMM_LO = 3'd1,
    S_IMM_HI = 3'd2,
    S_WRHL   = 3'd3,
    S_FETCH  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [1:0]          mcyc_q, mcyc_d;
  logic [1:0]          mode_q, mode_d;
  logic [NUM_REG-1:0]  y_lo_q, y_lo_d;
  logic [NUM_REG-1:0]  y_hi_q, y_hi_d;
  logic                accept_c;
  logic [NUM_REG-1:0]  dest_c;
  logic [NUM_REG-1:0]  a_sel_c;

  assign accept_c = i_Start && (i_Mode != MODE_RSV);

  // State, counters and latched operand selects.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      mcyc_q  <= '0;
      mode_q  <= '0;
      y_lo_q  <= '0;
      y_hi_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mcyc_q  <= mcyc_d;
      mode_q  <= mode_d;
      y_lo_q  <= y_lo_d;
      y_hi_q  <= y_hi_d;
    end
  end

  // Next state; the data step holds on i_Wait, FETCH may accept back-to-back.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mcyc_d  = mcyc_q;
    mode_d  = mode_q;
    y_lo_d  = y_lo_q;
    y_hi_d  = y_hi_q;
    case (state_q)
      S_IMM_LO, S_IMM_HI, S_WRHL: begin
        if (step_q == LAST_STEP) begin
          if (!i_Wait) begin
            step_d = '0;
            mcyc_d = mcyc_q + 2'd1;
            if (state_q == S_IMM_LO) begin
              case (mode_q)
                MODE_R8: state_d = S_FETCH;
                MODE_HL: state_d = S_WRHL;
                default: state_d = S_IMM_HI;
              endcase
            end else begin
              state_d = S_FETCH;
            end
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_FETCH: begin
        state_d = S_IDLE;
        step_d  = '0;
        mcyc_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
        mcyc_d  = '0;
      end
    endcase
    if ((state_q == S_IDLE || state_q == S_FETCH) && accept_c) begin
      state_d = S_IMM_LO;
      step_d  = '0;
      mcyc_d  = '0;
      mode_d  = i_Mode;
      y_lo_d  = i_Y_Lo;
      y_hi_d  = i_Y_Hi;
    end
  end

  // Control vector decoded from registered state only.
  always_comb begin
    o_Busy        = 1'b0;
    o_Done        = 1'b0;
    o_IR_Fetch    = 1'b0;
    o_Cycle_Step  = '0;
    o_Cycle_Count = '0;
    o_Read8       = '0;
    o_Write8      = '0;
    o_Read16      = '0;
    o_Write16     = '0;
    o_WriteALU8   = '0;
    o_Move_Reg    = 1'b0;
    o_Bus_In      = 1'b0;
    o_Bus_Out     = 1'b0;
    o_Address_Out = 1'b0;
    o_Increment16 = '0;
    a_sel_c       = NUM_REG'(1) << 7;
    dest_c        = '0;
    if (state_q != S_IDLE) begin
      o_Busy        = 1'b1;
      o_Cycle_Step  = NUM_STEPS'(1) << step_q;
      o_Cycle_Count = 4'(1) << mcyc_q;
    end
    case (state_q)
      S_IMM_LO, S_IMM_HI: begin
        // LD (HL),d8 parks the immediate in temp Z before the memory write.
        if (state_q == S_IMM_HI)     dest_c = y_hi_q;
        else if (mode_q == MODE_HL)  dest_c = NUM_REG'(1);
        else                         dest_c = y_lo_q;
        if (step_q == '0) begin
          o_Address_Out = 1'b1;
          o_Read16[5]   = 1'b1;
        end
        if (step_q == STEP_W'(1)) begin
          o_Increment16[0] = 1'b1;
          o_Write16[5]     = 1'b1;
        end
        if (step_q == LAST_STEP) begin
          o_Bus_In       = 1'b1;
          o_Write8       = dest_c & ~a_sel_c;
          o_WriteALU8[0] = (dest_c & a_sel_c) != '0;
        end
      end
      S_WRHL: begin
        if (step_q == '0) begin
          o_Address_Out = 1'b1;
          o_Read16[2]   = 1'b1;
        end
        if (step_q == LAST_STEP) begin
          o_Read8    = NUM_REG'(1);
          o_Move_Reg = 1'b1;
          o_Bus_Out  = 1'b1;
        end
      end
      S_FETCH: begin
        o_Done     = 1'b1;
        o_IR_Fetch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ld_imm_sequencer.sv
// Directed bench for ld_imm_sequencer: per-clock snapshots after the accept edge,
// checked against hand-computed values for NUM_STEPS=4.
module tb_ld_imm_sequencer;

  logic       clk, rst_n, start, wait_s;
  logic [1:0] mode;
  logic [7:0] y_lo, y_hi;
  logic       busy, done, irf, mv, bi, bo, ao;
  logic [3:0] step, cnt;
  logic [7:0] r8, w8;
  logic [5:0] r16, w16;
  logic [1:0] alu, inc;
  logic [46:0] all_o;

  int checks = 0;
  int failures = 0;
  int n_inc, n_bi, n_commit, done_at;

  logic [7:0] rec_w8  [0:15];
  logic [7:0] rec_r8  [0:15];
  logic [1:0] rec_alu [0:15];
  logic [1:0] rec_inc [0:15];
  logic [5:0] rec_r16 [0:15];
  logic [5:0] rec_w16 [0:15];
  logic [3:0] rec_step[0:15];
  logic [3:0] rec_cnt [0:15];
  logic       rec_bi  [0:15];
  logic       rec_bo  [0:15];
  logic       rec_mv  [0:15];
  logic       rec_ao  [0:15];
  logic       rec_irf [0:15];

  ld_imm_sequencer #(.NUM_STEPS(4), .NUM_REG(8)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start), .i_Mode(mode),
    .i_Y_Lo(y_lo), .i_Y_Hi(y_hi), .i_Wait(wait_s),
    .o_Busy(busy), .o_Done(done), .o_IR_Fetch(irf),
    .o_Cycle_Step(step), .o_Cycle_Count(cnt),
    .o_Read8(r8), .o_Write8(w8), .o_Read16(r16), .o_Write16(w16),
    .o_WriteALU8(alu), .o_Move_Reg(mv), .o_Bus_In(bi), .o_Bus_Out(bo),
    .o_Address_Out(ao), .o_Increment16(inc)
  );

  assign all_o = {busy, done, irf, step, cnt, r8, w8, r16, w16, alu, mv, bi, bo, ao, inc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic accept(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    start = 1'b1; mode = m; y_lo = lo; y_hi = hi;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Snapshot clocks 1..n after the accept edge; optional wait window and stray start.
  task automatic run(input int n, input int wlo, input int whi,
                     input int sk, input logic [1:0] smode, input logic [7:0] sylo);
    n_inc = 0; n_bi = 0; n_commit = 0; done_at = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      wait_s = (k >= wlo && k <= whi);
      if (k == sk) begin
        start = 1'b1; mode = smode; y_lo = sylo;
      end else begin
        start = 1'b0;
      end
      rec_w8[k] = w8;   rec_r8[k] = r8;   rec_alu[k] = alu; rec_inc[k] = inc;
      rec_r16[k] = r16; rec_w16[k] = w16; rec_step[k] = step; rec_cnt[k] = cnt;
      rec_bi[k] = bi;   rec_bo[k] = bo;   rec_mv[k] = mv;   rec_ao[k] = ao;
      rec_irf[k] = irf;
      if (inc != 2'b00) n_inc++;
      if (bi) n_bi++;
      if ((w8 != 8'h00 || alu != 2'b00) && !wait_s) n_commit++;
      if (done && done_at == 0) done_at = k;
      @(posedge clk);
    end
    #1 start = 1'b0; wait_s = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(tag, 64'(all_o), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wait_s = 1'b0; mode = 2'b00; y_lo = 8'h00; y_hi = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'(all_o), 64'd0);
    rst_n = 1'b1;

    // LD B,d8
    accept(2'b00, 8'h04, 8'h00);
    run(5, 0, 0, 0, 2'b00, 8'h00);
    chk("ldb_done_at", 64'(done_at), 64'd5);
    chk("ldb_step_clk1", 64'(rec_step[1]), 64'h1);
    chk("ldb_cnt_clk1", 64'(rec_cnt[1]), 64'h1);
    chk("ldb_addr_clk1", 64'({rec_ao[1], rec_r16[1]}), 64'({1'b1, 6'b100000}));
    chk("ldb_inc_clk2", 64'({rec_inc[2], rec_w16[2]}), 64'({2'b01, 6'b100000}));
    chk("ldb_inc_count", 64'(n_inc), 64'd1);
    chk("ldb_data_clk4", 64'({rec_bi[4], rec_w8[4], rec_alu[4]}), 64'({1'b1, 8'h04, 2'b00}));
    chk("ldb_irfetch_clk5", 64'(rec_irf[5]), 64'd1);
    idle_chk("ldb_idle_after");

    // LD A,d8 goes through the ALU write path
    accept(2'b00, 8'h80, 8'h00);
    run(5, 0, 0, 0, 2'b00, 8'h00);
    chk("lda_data_clk4", 64'({rec_alu[4], rec_w8[4]}), 64'({2'b01, 8'h00}));
    chk("lda_done_at", 64'(done_at), 64'd5);

    // LD (HL),d8
    accept(2'b01, 8'h04, 8'h00);
    run(9, 0, 0, 0, 2'b00, 8'h00);
    chk("ldhl_w8_z_clk4", 64'(rec_w8[4]), 64'h01);
    chk("ldhl_cnt_clk5", 64'(rec_cnt[5]), 64'h2);
    chk("ldhl_addr_clk5", 64'({rec_ao[5], rec_r16[5]}), 64'({1'b1, 6'b000100}));
    chk("ldhl_wr_clk8", 64'({rec_bo[8], rec_mv[8], rec_r8[8], rec_bi[8], rec_w8[8]}),
        64'({1'b1, 1'b1, 8'h01, 1'b0, 8'h00}));
    chk("ldhl_inc_count", 64'(n_inc), 64'd1);
    chk("ldhl_done_at", 64'(done_at), 64'd9);

    // LD BC,d16
    accept(2'b10, 8'h02, 8'h04);
    run(9, 0, 0, 0, 2'b00, 8'h00);
    chk("ldbc_w8_clk4", 64'(rec_w8[4]), 64'h02);
    chk("ldbc_w8_clk8", 64'(rec_w8[8]), 64'h04);
    chk("ldbc_inc_count", 64'(n_inc), 64'd2);
    chk("ldbc_done_at", 64'(done_at), 64'd9);
    chk("ldbc_cnt_clk9", 64'(rec_cnt[9]), 64'h4);

    // Wait states on the data step; stray start while busy is ignored
    accept(2'b00, 8'h04, 8'h00);
    run(8, 4, 6, 2, 2'b01, 8'h10);
    chk("wait_busin_clks", 64'(n_bi), 64'd4);
    chk("wait_commit_count", 64'(n_commit), 64'd1);
    chk("wait_w8_clk7", 64'(rec_w8[7]), 64'h04);
    chk("wait_done_at", 64'(done_at), 64'd8);
    idle_chk("wait_idle_after");

    // Back-to-back: new start sampled during FETCH
    accept(2'b00, 8'h04, 8'h00);
    run(5, 0, 0, 5, 2'b00, 8'h08);
    chk("b2b_first_done", 64'(done_at), 64'd5);
    run(5, 0, 0, 0, 2'b00, 8'h00);
    chk("b2b_second_step1", 64'({rec_step[1], rec_cnt[1]}), 64'({4'h1, 4'h1}));
    chk("b2b_second_w8", 64'(rec_w8[4]), 64'h08);
    chk("b2b_second_done", 64'(done_at), 64'd5);

    // Reset mid-sequence at M1 step1 of LD rr,d16
    accept(2'b10, 8'h02, 8'h04);
    run(5, 0, 0, 0, 2'b00, 8'h00);
    @(negedge clk);
    chk("rst_pos_m1s1", 64'({step, cnt}), 64'({4'h2, 4'h2}));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outputs", 64'(all_o), 64'd0);
    rst_n = 1'b1;
    start = 1'b1; mode = 2'b11; y_lo = 8'h04;
    @(posedge clk);
    #1 start = 1'b0;
    idle_chk("mode11_stays_idle");
    idle_chk("mode11_still_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
